// File: rtl/wb_stage_pkg.sv
// Shared constants for the writeback stage: bus widths, zero values and RV32I load funct3 codes.
// The misaligned-load check here is used only when WB_MISALIGN_TRAP_EN is defined.
package wb_stage_pkg;

    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_REG_AW = 5;

    localparam logic [WB_DATA_W-1:0] ZeroWord = 32'h0000_0000;
    localparam logic [WB_REG_AW-1:0] ZeroReg  = 5'd0;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Halfword loads need an even address; every non-byte, non-half code is a word load.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic res;
        res = 1'b0;
        case (funct3)
            LB, LBU: res = 1'b0;
            LH, LHU: res = addr_lo[0];
            default: res = (addr_lo != 2'b00);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load data alignment: selects the byte/half lane from a read word and extends it.
// Kept standalone so the store/MMIO path can reuse it.
module wb_stage_load_align
    import wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W = WB_DATA_W
) (
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] data_c_o
);

    logic [DATA_W-1:0] byte_sh;
    logic [DATA_W-1:0] half_sh;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;

    always_comb begin
        byte_sh  = rdata_i >> {addr_lo_i, 3'b000};
        half_sh  = rdata_i >> {addr_lo_i[1], 4'b0000};
        lane_b   = byte_sh[7:0];
        lane_h   = half_sh[15:0];
        data_c_o = rdata_i;
        case (funct3_i)
            LB:      data_c_o = {{(DATA_W-8){lane_b[7]}}, lane_b};
            LH:      data_c_o = {{(DATA_W-16){lane_h[15]}}, lane_h};
            LBU:     data_c_o = {{(DATA_W-8){1'b0}}, lane_b};
            LHU:     data_c_o = {{(DATA_W-16){1'b0}}, lane_h};
            default: data_c_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results next cycle, runs loads over the data bus, writes the register file.
// Optional WB_MISALIGN_TRAP_EN adds exc_misalign_o and suppresses bus requests for misaligned loads.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned REG_AW = WB_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_wen_i,
    input  logic              ex_is_load_i,
    input  logic [2:0]        ex_funct3_i,
    input  logic [DATA_W-1:0] ex_result_i,
    output logic              dmem_req_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              reg_wen_o,
    output logic [REG_AW-1:0] reg_waddr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
`ifdef WB_MISALIGN_TRAP_EN
    output logic              exc_misalign_o,
`endif
    output logic              stall_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lo_q, lo_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic              ready_q, ready_d;
    logic              req_q, req_d;
    logic              wen_q, wen_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] aligned_c;
`ifdef WB_MISALIGN_TRAP_EN
    logic              exc_q, exc_d;
`endif

    wb_stage_load_align #(.DATA_W(DATA_W)) u_load_align (
        .funct3_i  (f3_q),
        .addr_lo_i (lo_q),
        .rdata_i   (dmem_rdata_i),
        .data_c_o  (aligned_c)
    );

    // Next-state and registered-output logic; write enable defaults low so it only pulses.
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        f3_d    = f3_q;
        lo_d    = lo_q;
        addr_d  = addr_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
`ifdef WB_MISALIGN_TRAP_EN
        exc_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ex_valid_i) begin
                    if (ex_is_load_i) begin
                        rd_d   = ex_rd_i;
                        f3_d   = ex_funct3_i;
                        lo_d   = ex_result_i[1:0];
                        addr_d = {ex_result_i[DATA_W-1:2], 2'b00};
`ifdef WB_MISALIGN_TRAP_EN
                        if (is_misaligned(ex_funct3_i, ex_result_i[1:0])) begin
                            exc_d = 1'b1;
                        end else begin
                            state_d = REQ;
                        end
`else
                        state_d = REQ;
`endif
                    end else begin
                        wen_d   = ex_wen_i && (ex_rd_i != REG_AW'(ZeroReg));
                        waddr_d = ex_rd_i;
                        wdata_d = ex_result_i;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    wen_d   = (rd_q != REG_AW'(ZeroReg));
                    waddr_d = rd_q;
                    wdata_d = aligned_c;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        req_d   = (state_d == REQ);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rd_q    <= REG_AW'(ZeroReg);
            f3_q    <= 3'b000;
            lo_q    <= 2'b00;
            addr_q  <= DATA_W'(ZeroWord);
            ready_q <= 1'b1;
            req_q   <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= REG_AW'(ZeroReg);
            wdata_q <= DATA_W'(ZeroWord);
`ifdef WB_MISALIGN_TRAP_EN
            exc_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
            req_q   <= req_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
`ifdef WB_MISALIGN_TRAP_EN
            exc_q   <= exc_d;
`endif
        end
    end

    assign ex_ready_o  = ready_q;
    assign stall_o     = ~ready_q;
    assign dmem_req_o  = req_q;
    assign dmem_addr_o = addr_q;
    assign reg_wen_o   = wen_q;
    assign reg_waddr_o = waddr_q;
    assign reg_wdata_o = wdata_q;
`ifdef WB_MISALIGN_TRAP_EN
    assign exc_misalign_o = exc_q;
`endif

endmodule
